// File: rtl/uart_tx_arb.sv
// Multi-channel UART transmitter: per-requester byte FIFOs drained round-robin
// into a single 8N1/8N2 serializer.
module uart_tx_arb #(
  parameter int unsigned N_CH        = 2,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned CLK_FREQ_HZ = 50000000,
  parameter int unsigned BAUD_RATE   = 115200,
  parameter int unsigned STOP_BITS   = 1,
  localparam int unsigned CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_CH-1:0]     wr_valid,
  input  logic [8*N_CH-1:0]   wr_data,
  output logic [N_CH-1:0]     ch_full,
  output logic [N_CH-1:0]     ch_overflow,
  input  logic [N_CH-1:0]     ovf_clear,
  output logic [CH_W-1:0]     tx_ch,
  output logic                busy,
  output logic                uart_tx
);

  localparam int unsigned DIV    = CLK_FREQ_HZ / BAUD_RATE;
  localparam int unsigned BAUD_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t            state_q, state_d;
  logic [N_CH-1:0]   not_empty;
  logic [N_CH-1:0]   pop;
  logic [7:0]        head [N_CH];
  logic              grant_vld;
  logic [CH_W-1:0]   grant_ch;
  logic [CH_W-1:0]   rr_ptr;
  logic [BAUD_W-1:0] baud_cnt;
  logic              baud_end;
  logic [2:0]        bit_cnt;
  logic [7:0]        shreg;
  logic              tx_bit_c;

  // Per-channel FIFO; a write to a full channel is dropped and flagged.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count, count_next;
    logic             full_q, ovf_q, push;

    assign push         = wr_valid[i] & ~full_q;
    assign count_next   = count + CNT_W'(push) - CNT_W'(pop[i]);
    assign not_empty[i] = (count != '0);
    assign head[i]      = mem[rd_ptr];
    assign ch_full[i]     = full_q;
    assign ch_overflow[i] = ovf_q;

    always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_data[8*i +: 8];
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
        full_q <= 1'b0;
        ovf_q  <= 1'b0;
      end else begin
        if (push)   wr_ptr <= wr_ptr + 1'b1;
        if (pop[i]) rd_ptr <= rd_ptr + 1'b1;
        count  <= count_next;
        full_q <= (count_next == CNT_W'(DEPTH));
        if (wr_valid[i] && full_q) ovf_q <= 1'b1;
        else if (ovf_clear[i])     ovf_q <= 1'b0;
      end
    end
  end

  // Round-robin scan from rr_ptr+1; iterating downward leaves the nearest winner.
  always_comb begin : arb
    int unsigned idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant_ch  = rr_ptr;
    for (int unsigned off = N_CH; off >= 1; off--) begin
      idx = (32'(rr_ptr) + off) % N_CH;
      if (not_empty[CH_W'(idx)]) begin
        grant_vld = 1'b1;
        grant_ch  = CH_W'(idx);
      end
    end
  end

  always_comb begin
    pop = '0;
    if (state_q == S_IDLE && grant_vld) pop[grant_ch] = 1'b1;
  end

  assign busy     = (|not_empty) | (state_q != S_IDLE);
  assign baud_end = (baud_cnt == BAUD_W'(DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (grant_vld) state_d = S_START;
      S_START: if (baud_end) state_d = S_DATA;
      S_DATA:  if (baud_end && bit_cnt == 3'd7) state_d = S_STOP;
      S_STOP:  if (baud_end && bit_cnt == 3'(STOP_BITS - 1)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tx_bit_c = 1'b1;
    unique case (state_q)
      S_START: tx_bit_c = 1'b0;
      S_DATA:  tx_bit_c = shreg[0];
      default: tx_bit_c = 1'b1;
    endcase
  end

  // Serializer datapath; baud phase restarts at every grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      tx_ch    <= '0;
      rr_ptr   <= CH_W'(N_CH - 1);
      uart_tx  <= 1'b1;
    end else begin
      uart_tx <= tx_bit_c;
      if (state_q == S_IDLE) begin
        baud_cnt <= '0;
        bit_cnt  <= '0;
        if (grant_vld) begin
          shreg  <= head[grant_ch];
          tx_ch  <= grant_ch;
          rr_ptr <= grant_ch;
        end
      end else begin
        baud_cnt <= baud_end ? '0 : baud_cnt + 1'b1;
        if (baud_end) begin
          if (state_q == S_DATA) shreg <= shreg >> 1;
          bit_cnt <= (state_d != state_q) ? 3'd0 : bit_cnt + 3'd1;
        end
      end
    end
  end

endmodule

// File: doc/uart_tx_arb.md
Name: uart_tx_arb

Overview:
- Multi-channel UART transmit front end for the dual-issue torv32 SoC. Replaces the single-requester emitter, which loses a byte when both IO ports write the UART in the same cycle.
- Each IO requester (a/b ports, optional coprocessor debug) gets its own byte FIFO. A round-robin arbiter drains the FIFOs into one 8N1/8N2 serializer.
- Per-channel full flags feed the IO status word (busy bit 9). A global busy flag lets the bench drain output before halt.

Parameters:
- N_CH, 2, number of requester channels (1..8).
- DEPTH, 4, entries per channel FIFO; power of two, at least 2.
- CLK_FREQ_HZ, 50000000, clock frequency.
- BAUD_RATE, 115200, line rate. DIV = CLK_FREQ_HZ/BAUD_RATE, truncated (434 at defaults).
- STOP_BITS, 1, number of stop bits (1 or 2).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- wr_valid  in  N_CH  per-channel byte write strobe, single cycle.
- wr_data  in  8*N_CH  packed bytes; channel i uses [8i+7:8i].
- ch_full  out  N_CH  channel FIFO holds DEPTH entries.
- ch_overflow  out  N_CH  sticky: a write was dropped on a full channel.
- ovf_clear  in  N_CH  clears the matching ch_overflow bit.
- tx_ch  out  clog2(N_CH) (min 1)  channel of the frame in flight; holds the last value when idle.
- busy  out  1  any FIFO non-empty or serializer not IDLE.
- uart_tx  out  1  serial line, idles high.

Behaviour:
- Reset values (async assert): all FIFOs empty, ch_full=0, ch_overflow=0, tx_ch=0, busy=0, uart_tx=1, FSM=IDLE, round-robin pointer=N_CH-1 (channel 0 wins first). Deassertion is taken synchronously by the surrounding Clockworks.
- Push:
  - wr_valid[i] & !ch_full[i] writes wr_data byte i at the rising edge.
  - ch_full is registered and reflects the count at cycle start.
  - A write to a full FIFO is dropped even if a pop occurs in the same cycle. The drop sets ch_overflow[i].
  - Pointers wrap modulo DEPTH. Count has width clog2(DEPTH)+1.
- Simultaneous writes: all channels may push in the same cycle, each to its own FIFO. No loss unless that channel is full.
- ch_overflow: if set and ovf_clear occur in the same cycle, set wins.
- Arbiter (in IDLE):
  - Scans channels starting at pointer+1, with wrap, for the first non-empty FIFO.
  - In that same cycle it pops the head into the shift register, sets tx_ch and the pointer to the winner, and moves to START.
  - No non-empty FIFO: stay IDLE.
- FSM IDLE -> START -> DATA -> STOP -> IDLE:
  - START: uart_tx=0 for DIV cycles.
  - DATA: 8 bits, LSB first, DIV cycles each; bit counter 0..7.
  - STOP: uart_tx=1 for STOP_BITS*DIV cycles.
  - IDLE: exactly one cycle between frames. Frame period is 1+DIV*(9+STOP_BITS) cycles.
- Baud counter: counts 0..DIV-1 and reloads on each bit boundary. It is reset on entry to START so phase is aligned to the grant.
- Latency: a write at edge k makes the FIFO non-empty at k+1. Grant/pop happens at edge k+1. uart_tx falls after edge k+2.
- busy: combinational OR of the FIFO non-empty flags and (FSM != IDLE). It goes low in the IDLE cycle after the last STOP if all FIFOs are empty.
- Reset mid-frame: uart_tx returns high immediately, queued bytes are discarded, and the partial frame is not resumed.

Test Plan:
- Single byte, default parameters: wr_valid=01, wr_data[7:0]=0x55. The line shows a 0 start bit, then data 1,0,1,0,1,0,1,0 (LSB first), then a 1 stop bit, each 434 cycles. Start begins 2 cycles after the write edge. busy=0 in the IDLE cycle after the stop bit.
- Collision: same cycle wr_valid=11, bytes 0x41 ('A') on ch0 and 0x42 ('B') on ch1. Output is 'A' then 'B', both complete with no loss. tx_ch goes 0 then 1. The gap between frames is exactly 1 idle cycle.
- Overflow, DEPTH=4: five writes to ch1 while ch0 is transmitting. ch_full[1]=1 after the 4th write. The 5th byte is dropped and ch_overflow[1]=1. Exactly 4 ch1 bytes are emitted. ovf_clear[1] pulse -> ch_overflow[1]=0. Clear asserted together with a new drop -> stays 1.
- Fairness: ch0 refilled every frame, one byte pushed to ch1. The ch1 byte is transmitted no later than the frame after the current one; frames alternate ch0/ch1 while both are pending.
- Reset mid-DATA: assert reset at bit 3 of a frame with 2 bytes queued. uart_tx=1 during reset, busy=0, all FIFOs empty, no residual bits. A fresh write after release produces a complete clean frame.
- STOP_BITS=2, BAUD_RATE=1000000: DIV=50. Stop bit high for 100 cycles. Back-to-back frame period = 1+50*11 = 551 cycles.
